heli_motion_ctrl: RTL and testbench
===================================

# heli_motion_ctrl

Per-frame game-state engine for the helicopter game. It sits directly upstream of the pixel/colour stage in `helicopter_game`. Once per video frame it advances helicopter vertical position (gravity vs. button thrust), scrolls a single wall obstacle with a pseudo-random gap, detects collisions and keeps score. The pixel stage compares `CounterX`/`CounterY` against these registered outputs to draw sprites.

## Interface
- `HELI_X`, 100: fixed left x of helicopter sprite
- `HELI_W`, 24: helicopter width, px
- `HELI_H`, 16: helicopter height, px
- `START_Y`, 232: helicopter top y in IDLE
- `WALL_W`, 20: wall width, px
- `GAP_H`, 120: wall gap height, px
- `GRAVITY`, 1: velocity increment per frame, px/frame
- `THRUST`, 2: velocity decrement per frame while button held
- `VMAX`, 8: velocity saturation magnitude
- `WALL_SPEED`, 2: wall leftward step per frame, px
- `ClkPort  in  1`: system clock; the block runs entirely in this domain
- `reset  in  1`: asynchronous, active-high
- `btn_up  in  1`: raw flight button, asynchronous to ClkPort
- `vga_v_sync  in  1`: active-low vsync from `hvsync_generator`
- `heli_y  out  10`: helicopter top y
- `wall_x  out  10`: wall left x; 640 = off-screen
- `gap_y  out  10`: top y of wall gap
- `crashed  out  1`: high while in CRASH
- `playing  out  1`: high while in FLY
- `score  out  16`: walls passed, saturating

## Operation
- Frame tick: `vga_v_sync` passes through a 2-FF synchronizer. The tick is a 1-cycle pulse on the synchronized falling edge. `btn_up` also passes through a 2-FF synchronizer, and its level is sampled only at a tick. A "new press" means the button is sampled 1 at this tick and was sampled 0 at the previous tick.
- LFSR: 16-bit, free-running every ClkPort cycle. Polynomial x^16+x^14+x^13+x^11+1. Seed 0xACE1 on reset.
- States: IDLE, FLY, CRASH. Reset state is IDLE.
- IDLE: `heli_y`=START_Y, velocity=0, `wall_x`=640, `gap_y`=180, and `score` holds its value. A new press moves the block to FLY and clears `score` to 0.
- FLY, evaluated on each tick:
  - Velocity (signed 6-bit): v' = v + GRAVITY − (btn ? THRUST : 0), saturated to [−VMAX, +VMAX].
  - y' = heli_y + v', computed signed 11-bit.
  - If y' < 0, clamp to 0 and crash.
  - If y' > 480−HELI_H, clamp to 480−HELI_H and crash.
  - Wall: if wall_x < WALL_SPEED, then wall_x' = 640, gap_y' = 40 + lfsr[7:0] (range 40..295), and score increments, saturating at 0xFFFF. Otherwise wall_x' = wall_x − WALL_SPEED.
  - Collision uses the updated values. It fires when both of these hold:
    - x overlap: wall_x' ≤ HELI_X+HELI_W−1 and wall_x'+WALL_W−1 ≥ HELI_X.
    - Outside the gap: y' < gap_y' or y'+HELI_H > gap_y'+GAP_H.
  - Any crash condition moves the block to CRASH. The clamped and updated positions are still written.
- CRASH: all positions are frozen and `crashed`=1. A new press returns the block to IDLE, and score stays visible.
- Button presses between ticks are ignored.

## Timing
- Reset values: `heli_y`=232, `wall_x`=640, `gap_y`=180, `crashed`=0, `playing`=0, `score`=0, velocity=0, LFSR=0xACE1.
- Tick latency: the tick asserts 3 ClkPort cycles after the `vga_v_sync` falling edge (2 synchronizer stages plus the edge register).
- All outputs are registered. They change only in the cycle after a tick, and all of them change in that same cycle. They are stable for the rest of the frame.
- `playing`/`crashed` follow the state register with no extra latency.
- Reset asserted mid-frame or mid-update forces all reset values immediately. The first tick after reset release cannot be a new press unless the button was sampled 1 at that tick.
- Both a wall wrap and a collision in one tick: the score increments and the crash is taken.

## Structure
- Package `heli_game_pkg` holds: screen constants `H_ACTIVE`=640 and `V_ACTIVE`=480, the state encoding (IDLE/FLY/CRASH), and `LFSR_SEED`.
- Sub-module `frame_tick_gen` contains the vsync synchronizer and edge detector, plus the button synchronizer, and outputs `tick` and `btn_s`.
- The physics datapath and FSM live in the top.

## Test plan
- Reset, then 5 ticks with no press → IDLE held, `heli_y`=232, `wall_x`=640, `playing`=0.
- Press at tick 1, release at tick 2, then free-fall → FLY. Velocity goes 1,2,…,8 and stays saturated at 8. `heli_y` follows 232→233→235→…, and `wall_x` goes 638, 636, ….
- Button held continuously from FLY start at y=232 → v=−1,−2,…,−8 (saturated). `heli_y` clamps at 0, then CRASH with `crashed`=1 in the next cycle.
- Force gap_y=40 with the wall approaching, helicopter at y=232 → when wall_x' ≤ 123, CRASH is asserted and positions freeze on later ticks.
- Hold heli_y inside the gap (gap_y=180, heli_y=200) while the wall passes x=0 → wall_x reloads to 640, `score` goes 0→1, and gap_y = 40+lfsr[7:0].
- Assert reset 2 cycles after a tick while in CRASH → all outputs return to their reset values immediately, and the state is IDLE.

Source files
------------

// File: rtl/heli_game_pkg.sv
// Shared screen constants, FSM encoding and LFSR helpers for the helicopter game.
package heli_game_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int GAP_BASE  = 40;
  localparam int IDLE_GAP_Y = 180;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLY   = 2'd1,
    ST_CRASH = 2'd2
  } state_t;

  // Fibonacci form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync/button synchronizers; emits a one-cycle tick on the synced vsync falling edge.
module frame_tick_gen (
  input  logic ClkPort,
  input  logic reset,
  input  logic vga_v_sync,
  input  logic btn_up,
  output logic tick,
  output logic btn_s
);

  // [1:0] are the synchronizer, [2] is the edge-detect history
  logic [2:0] vs_pipe;
  logic [1:0] btn_pipe;

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      vs_pipe  <= 3'b111;
      btn_pipe <= 2'b00;
      tick     <= 1'b0;
    end else begin
      vs_pipe  <= {vs_pipe[1:0], vga_v_sync};
      btn_pipe <= {btn_pipe[0], btn_up};
      tick     <= vs_pipe[2] & ~vs_pipe[1];
    end
  end

  assign btn_s = btn_pipe[1];

endmodule

// File: rtl/heli_motion_ctrl.sv
// Per-frame helicopter game state: flight physics, scrolling wall, collisions and score.
module heli_motion_ctrl
  import heli_game_pkg::*;
#(
  parameter int HELI_X     = 100,
  parameter int HELI_W     = 24,
  parameter int HELI_H     = 16,
  parameter int START_Y    = 232,
  parameter int WALL_W     = 20,
  parameter int GAP_H      = 120,
  parameter int GRAVITY    = 1,
  parameter int THRUST     = 2,
  parameter int VMAX       = 8,
  parameter int WALL_SPEED = 2
) (
  input  logic        ClkPort,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        vga_v_sync,
  output logic [9:0]  heli_y,
  output logic [9:0]  wall_x,
  output logic [9:0]  gap_y,
  output logic        crashed,
  output logic        playing,
  output logic [15:0] score
);

  localparam int Y_MAX = V_ACTIVE - HELI_H;
  localparam logic signed [6:0] VMAX7 = 7'(VMAX);

  logic tick, btn_s;

  frame_tick_gen u_tick (
    .ClkPort    (ClkPort),
    .reset      (reset),
    .vga_v_sync (vga_v_sync),
    .btn_up     (btn_up),
    .tick       (tick),
    .btn_s      (btn_s)
  );

  state_t             state;
  logic signed [5:0]  vel;
  logic [15:0]        lfsr;
  logic               btn_prev;
  logic               new_press;

  logic signed [6:0]  v_sum;
  logic signed [5:0]  v_nxt;
  logic signed [10:0] y_sum;
  logic [9:0]         y_nxt, wall_nxt, gap_nxt;
  logic               wrap, hit_edge, x_ovl, out_gap, hit_wall;
  logic [15:0]        score_inc;

  assign new_press = btn_s & ~btn_prev;
  assign crashed   = (state == ST_CRASH);
  assign playing   = (state == ST_FLY);
  assign score_inc = (score == 16'hFFFF) ? score : score + 16'd1;

  always_comb begin
    v_sum = 7'(vel) + 7'(GRAVITY) - (btn_s ? 7'(THRUST) : 7'sd0);
    if (v_sum > VMAX7)       v_nxt = 6'(VMAX);
    else if (v_sum < -VMAX7) v_nxt = 6'(-VMAX);
    else                     v_nxt = v_sum[5:0];

    y_sum    = $signed({1'b0, heli_y}) + 11'(v_nxt);
    y_nxt    = y_sum[9:0];
    hit_edge = 1'b0;
    if (y_sum[10]) begin
      y_nxt    = 10'd0;
      hit_edge = 1'b1;
    end else if (y_sum > 11'(Y_MAX)) begin
      y_nxt    = 10'(Y_MAX);
      hit_edge = 1'b1;
    end

    // A wall leaving the left edge respawns on the right with a fresh gap
    wrap = wall_x < 10'(WALL_SPEED);
    if (wrap) begin
      wall_nxt = 10'(H_ACTIVE);
      gap_nxt  = 10'(GAP_BASE) + {2'b00, lfsr[7:0]};
    end else begin
      wall_nxt = wall_x - 10'(WALL_SPEED);
      gap_nxt  = gap_y;
    end

    x_ovl   = ({1'b0, wall_nxt} <= 11'(HELI_X + HELI_W - 1)) &&
              ({1'b0, wall_nxt} + 11'(WALL_W - 1) >= 11'(HELI_X));
    out_gap = ({1'b0, y_nxt} < {1'b0, gap_nxt}) ||
              ({1'b0, y_nxt} + 11'(HELI_H) > {1'b0, gap_nxt} + 11'(GAP_H));
    hit_wall = x_ovl & out_gap;
  end

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      vel      <= '0;
      heli_y   <= 10'(START_Y);
      wall_x   <= 10'(H_ACTIVE);
      gap_y    <= 10'(IDLE_GAP_Y);
      score    <= '0;
      lfsr     <= LFSR_SEED;
      btn_prev <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (tick) begin
        btn_prev <= btn_s;
        case (state)
          ST_IDLE: begin
            if (new_press) begin
              state <= ST_FLY;
              score <= '0;
            end
          end
          ST_FLY: begin
            vel    <= v_nxt;
            heli_y <= y_nxt;
            wall_x <= wall_nxt;
            gap_y  <= gap_nxt;
            if (wrap) score <= score_inc;
            if (hit_edge || hit_wall) state <= ST_CRASH;
          end
          ST_CRASH: begin
            // Re-arm the playfield on the way back to IDLE; score stays on screen
            if (new_press) begin
              state  <= ST_IDLE;
              vel    <= '0;
              heli_y <= 10'(START_Y);
              wall_x <= 10'(H_ACTIVE);
              gap_y  <= 10'(IDLE_GAP_Y);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_heli_motion_ctrl.sv
// Frame-stepped bench: a behavioural game model feeds a scoreboard; hand tables pin key sequences.
module tb_heli_motion_ctrl;

  logic        ClkPort = 1'b0;
  logic        reset;
  logic        btn_up;
  logic        vga_v_sync;
  logic [9:0]  heli_y, wall_x, gap_y;
  logic        crashed, playing;
  logic [15:0] score;

  heli_motion_ctrl dut (
    .ClkPort    (ClkPort),
    .reset      (reset),
    .btn_up     (btn_up),
    .vga_v_sync (vga_v_sync),
    .heli_y     (heli_y),
    .wall_x     (wall_x),
    .gap_y      (gap_y),
    .crashed    (crashed),
    .playing    (playing),
    .score      (score)
  );

  always #5 ClkPort = ~ClkPort;

  typedef struct packed {
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  g;
    logic        cr;
    logic        pl;
    logic [15:0] sc;
  } exp_t;

  typedef struct {
    bit btn;
    int y;
    int w;
    bit pl;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q[$];
  exp_t last;

  // reference LFSR, free-running alongside the DUT
  logic [15:0] lfsr_m;
  always @(posedge ClkPort or posedge reset)
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

  // game model: 0 idle, 1 fly, 2 crash
  int m_state, m_y, m_v, m_w, m_g, m_score;
  bit m_bprev;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic m_reset();
    m_state = 0; m_y = 232; m_v = 0; m_w = 640; m_g = 180; m_score = 0; m_bprev = 0;
    last = '{y: 10'd232, w: 10'd640, g: 10'd180, cr: 1'b0, pl: 1'b0, sc: 16'd0};
    q.delete();
  endtask

  task automatic model_tick(input bit b, input logic [15:0] l);
    bit np, cr;
    int v, y;
    np = b && !m_bprev;
    m_bprev = b;
    case (m_state)
      0: if (np) begin m_state = 1; m_score = 0; end
      1: begin
        v = m_v + 1 - (b ? 2 : 0);
        if (v > 8) v = 8;
        if (v < -8) v = -8;
        m_v = v;
        y = m_y + v;
        cr = 0;
        if (y < 0) begin y = 0; cr = 1; end
        if (y > 464) begin y = 464; cr = 1; end
        if (m_w < 2) begin
          m_w = 640;
          m_g = 40 + int'(l[7:0]);
          if (m_score < 65535) m_score++;
        end else m_w -= 2;
        if (m_w <= 123 && m_w + 19 >= 100 && (y < m_g || y + 16 > m_g + 120)) cr = 1;
        m_y = y;
        if (cr) m_state = 2;
      end
      default: if (np) begin
        m_state = 0; m_y = 232; m_v = 0; m_w = 640; m_g = 180;
      end
    endcase
  endtask

  function automatic bit ctrl(input int tgt);
    return (m_y + m_v + 1 > tgt);
  endfunction

  // One video frame: settle button, drop vsync, check hold before the update edge, score after.
  task automatic frame(input bit b);
    exp_t e, cur;
    btn_up = b;
    repeat (4) @(negedge ClkPort);
    vga_v_sync = 1'b0;
    repeat (3) @(posedge ClkPort);
    @(negedge ClkPort);
    cur = '{y: heli_y, w: wall_x, g: gap_y, cr: crashed, pl: playing, sc: score};
    chk("hold_before_update", 64'(cur), 64'(last));
    model_tick(b, lfsr_m);
    e = '{y: 10'(m_y), w: 10'(m_w), g: 10'(m_g), cr: (m_state == 2), pl: (m_state == 1),
          sc: 16'(m_score)};
    q.push_back(e);
    @(posedge ClkPort);
    #1;
    if (q.size() == 0) chk("scoreboard_empty", 64'(1), 64'(0));
    else begin
      e = q.pop_front();
      chk("heli_y",  64'(heli_y),  64'(e.y));
      chk("wall_x",  64'(wall_x),  64'(e.w));
      chk("gap_y",   64'(gap_y),   64'(e.g));
      chk("crashed", 64'(crashed), 64'(e.cr));
      chk("playing", 64'(playing), 64'(e.pl));
      chk("score",   64'(score),   64'(e.sc));
      last = e;
    end
    vga_v_sync = 1'b1;
    @(negedge ClkPort);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_heli_y"},  64'(heli_y),  64'd232);
    chk({tag, "_wall_x"},  64'(wall_x),  64'd640);
    chk({tag, "_gap_y"},   64'(gap_y),   64'd180);
    chk({tag, "_crashed"}, 64'(crashed), 64'd0);
    chk({tag, "_playing"}, 64'(playing), 64'd0);
    chk({tag, "_score"},   64'(score),   64'd0);
  endtask

  vec_t tbl[13];

  initial begin
    // press, release, free fall to +8 saturation, then thrust
    tbl[0]  = '{1, 232, 640, 1};
    tbl[1]  = '{0, 233, 638, 1};
    tbl[2]  = '{0, 235, 636, 1};
    tbl[3]  = '{0, 238, 634, 1};
    tbl[4]  = '{0, 242, 632, 1};
    tbl[5]  = '{0, 247, 630, 1};
    tbl[6]  = '{0, 253, 628, 1};
    tbl[7]  = '{0, 260, 626, 1};
    tbl[8]  = '{0, 268, 624, 1};
    tbl[9]  = '{0, 276, 622, 1};
    tbl[10] = '{1, 283, 620, 1};
    tbl[11] = '{1, 289, 618, 1};
    tbl[12] = '{1, 294, 616, 1};

    reset = 1'b1; btn_up = 1'b0; vga_v_sync = 1'b1;
    m_reset();
    repeat (3) @(negedge ClkPort);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge ClkPort);

    // idle frames without a press
    for (int i = 0; i < 5; i++) frame(1'b0);
    chk("idle_playing", 64'(playing), 64'd0);
    chk("idle_heli_y",  64'(heli_y),  64'd232);
    chk("idle_wall_x",  64'(wall_x),  64'd640);

    for (int i = 0; i < 13; i++) begin
      frame(tbl[i].btn);
      chk($sformatf("tbl%0d_heli_y", i),  64'(heli_y),  64'(tbl[i].y));
      chk($sformatf("tbl%0d_wall_x", i),  64'(wall_x),  64'(tbl[i].w));
      chk($sformatf("tbl%0d_playing", i), 64'(playing), 64'(tbl[i].pl));
    end

    // keep thrusting into the ceiling
    for (int i = 0; i < 120 && m_state != 2; i++) frame(1'b1);
    chk("ceil_heli_y",  64'(heli_y),  64'd0);
    chk("ceil_crashed", 64'(crashed), 64'd1);
    chk("ceil_playing", 64'(playing), 64'd0);
    frame(1'b1);
    frame(1'b0);
    chk("frozen_heli_y", 64'(heli_y), 64'd0);

    // back to IDLE, then start a new game and hover inside the gap while the wall passes
    frame(1'b1);
    chk("to_idle_heli_y", 64'(heli_y), 64'd232);
    chk("to_idle_wall_x", 64'(wall_x), 64'd640);
    frame(1'b0);
    frame(1'b1);
    chk("fly2_playing", 64'(playing), 64'd1);
    for (int i = 0; i < 400 && m_score == 0 && m_state != 2; i++) frame(ctrl(232));
    chk("pass_score",   64'(score),   64'd1);
    chk("pass_wall_x",  64'(wall_x),  64'd640);
    chk("pass_crashed", 64'(crashed), 64'd0);
    chk("pass_gap_rng", 64'(gap_y >= 10'd40 && gap_y <= 10'd295), 64'd1);

    // free fall into the floor
    for (int i = 0; i < 100 && m_state != 2; i++) frame(1'b0);
    chk("floor_heli_y",  64'(heli_y),  64'd464);
    chk("floor_crashed", 64'(crashed), 64'd1);

    // score stays visible in IDLE, clears on the next start
    frame(1'b1);
    chk("idle_score_kept", 64'(score), 64'd1);
    frame(1'b0);
    frame(1'b1);
    chk("fly3_score", 64'(score), 64'd0);

    // hover below the gap until the wall reaches the helicopter
    for (int i = 0; i < 400 && m_state != 2; i++) frame(ctrl(400));
    chk("wall_hit_crashed", 64'(crashed), 64'd1);
    chk("wall_hit_wall_x",  64'(wall_x),  64'd122);
    frame(1'b0);
    frame(1'b0);
    chk("wall_frozen_x", 64'(wall_x), 64'd122);

    // asynchronous reset shortly after a tick while crashed
    frame(1'b0);
    @(posedge ClkPort);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    m_reset();
    @(negedge ClkPort);
    reset = 1'b0;
    @(negedge ClkPort);
    frame(1'b1);
    chk("post_reset_press", 64'(playing), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
